systolic_pe_mac: RTL
====================

Name: systolic_pe_mac

Overview:
Parametrised successor to the team's basic systolic PE. It adds:
- valid-qualified operands on both axes
- a selectable signed/unsigned multiply
- a 2-stage MAC pipeline with optional accumulator saturation
- a drain chain that shifts each PE's result out along its column

Instances tile into an R x C array. Operands flow west->east and north->south, and results drain through acc_in/acc_out.

Parameters:
DATA_W, 8, operand width (bits)
ACC_W, 32, accumulator width; must be >= 2*DATA_W
SAT_EN, 1, 1 = clamp accumulator on overflow; 0 = wrap modulo 2^ACC_W
CNT_W, 16, width of the MAC counter

Ports:
clk  in  1  clock; all flops update on the rising edge
rst  in  1  reset, asynchronous, active-high; clears all state
clear  in  1  synchronous clear of accumulator, counter, flags and pipeline; state returns to ACC
mode_signed  in  1  1 = operands are two's complement, 0 = unsigned; sampled per operand pair at stage 1
west_data  in  DATA_W  row operand
west_valid  in  1  row operand valid
north_data  in  DATA_W  column operand
north_valid  in  1  column operand valid
east_data  out  DATA_W  registered copy of west_data
east_valid  out  1  registered copy of west_valid
south_data  out  DATA_W  registered copy of north_data
south_valid  out  1  registered copy of north_valid
drain  in  1  start result drain (single-cycle pulse)
acc_in  in  ACC_W  drain chain input from the upstream PE
acc_in_valid  in  1  acc_in valid
acc_out  out  ACC_W  drain chain output
acc_out_valid  out  1  acc_out valid
mac_count  out  CNT_W  number of accumulated products; saturates at all-ones
overflow  out  1  sticky; set when any accumulate overflows ACC_W
protocol_err  out  1  sticky; set when exactly one of west_valid/north_valid is high in ACC state

Behaviour:
- Reset (rst=1, asynchronous):
  - every output = 0
  - internal accumulator and product register = 0
  - prod_v = 0
  - state = ACC
- Forwarding: every cycle, regardless of state, east/south data and valid are registered copies of west/north with 1-cycle latency. Forwarding is unaffected by clear.
- Stage 1:
  - fire = west_valid & north_valid & (state==ACC) & !clear.
  - On fire: prod_r <= west_data*north_data as a 2*DATA_W product, signed or unsigned per mode_signed that cycle; prod_s <= mode_signed; prod_v <= fire.
- Stage 2: when prod_v=1:
  - acc <= acc + ext(prod_r), where ext sign-extends if prod_s=1 and zero-extends otherwise.
  - mac_count increments, saturating at all-ones.
- Latency: a pair sampled at edge N is visible in acc at edge N+2.
- Overflow:
  - Signed: detected when the ACC_W+1-bit result differs in its top two bits. Unsigned: detected on carry-out.
  - On overflow, overflow <= 1 (sticky).
  - SAT_EN=1: acc clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1) (signed), or to 2^ACC_W-1 (unsigned).
  - SAT_EN=0: acc wraps.
- States:
  - ACC: normal accumulation. drain=1 -> FLUSH.
  - FLUSH: one cycle; lets an in-flight prod_v land in acc. No new fire. -> EMIT.
  - EMIT: one cycle; acc_out <= acc, acc_out_valid <= 1. -> PASS.
  - PASS: acc_out <= acc_in and acc_out_valid <= acc_in_valid, registered each cycle. Stays in PASS until clear.
- In ACC and FLUSH, acc_out_valid = 0 and acc_out holds its last value.
- drain in any state other than ACC is ignored.
- Operands arriving outside ACC: forwarded, not accumulated, protocol_err not set.
- clear:
  - Highest priority after rst.
  - Next edge: acc = 0, mac_count = 0, overflow = 0, protocol_err = 0, prod_v = 0, acc_out_valid = 0, state = ACC.
  - A pair presented in the same cycle as clear is dropped.
  - clear and drain in the same cycle: clear wins and drain is ignored.
- mode_signed may change between pairs; each product uses its own sampled mode.
- rst asserted mid-pipeline: in-flight product discarded immediately; no partial update.

Test Plan:
1. Unsigned (mode_signed=0), pairs (3,5),(255,255),(0,7),(10,10) on consecutive cycles -> acc=65140 two edges after the last pair; mac_count=4; east/south echo each input one cycle later.
2. Signed, pairs (-128,-128),(-1,127) -> drained acc_out=16257 (0x00003F81); overflow=0.
3. ACC_W=16, unsigned, (255,255) twice:
   - SAT_EN=1 -> acc=65535, overflow=1.
   - SAT_EN=0 -> acc=64514, overflow=1.
4. Two-PE chain (PE1.acc_out -> PE0.acc_in), accs PE0=200 and PE1=100, drain to both at edge T, with a pair firing at T-1 into PE0 of product 6:
   - PE0.acc_out=206 valid at T+2 (from EMIT).
   - PE0.acc_out=100 valid at T+3 (forwarded PE1 emission).
   - Then acc_out_valid=0.
5. west_valid=1 with north_valid=0 in ACC -> no accumulate, protocol_err=1; then clear together with a valid pair -> acc=0, mac_count=0, flags 0, pair dropped.
6. rst pulsed asynchronously between edges while prod_v=1 -> all outputs 0 immediately; after release, pair (2,3) -> acc=6.

Source files
------------

// File: rtl/systolic_pe_mac.sv
// Systolic MAC processing element: forwards operands east/south, accumulates products, drains results down its column.
// Latency: forwarding 1 cycle, product-to-acc 2 cycles, drain to acc_out 2 cycles after FLUSH; no backpressure (free-running).
module systolic_pe_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SAT_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              mode_signed,
  input  logic [DATA_W-1:0] west_data,
  input  logic              west_valid,
  input  logic [DATA_W-1:0] north_data,
  input  logic              north_valid,
  output logic [DATA_W-1:0] east_data,
  output logic              east_valid,
  output logic [DATA_W-1:0] south_data,
  output logic              south_valid,
  input  logic              drain,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              acc_in_valid,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_out_valid,
  output logic [CNT_W-1:0]  mac_count,
  output logic              overflow,
  output logic              protocol_err
);

  typedef enum logic [1:0] {ST_ACC, ST_FLUSH, ST_EMIT, ST_PASS} state_t;

  state_t                r_state;
  logic [DATA_W-1:0]     r_east_data;
  logic                  r_east_valid;
  logic [DATA_W-1:0]     r_south_data;
  logic                  r_south_valid;
  logic [2*DATA_W-1:0]   r_prod;
  logic                  r_prod_s;
  logic                  r_prod_v;
  logic [ACC_W-1:0]      r_acc;
  logic [ACC_W-1:0]      r_acc_out;
  logic                  r_acc_out_valid;
  logic [CNT_W-1:0]      r_mac_count;
  logic                  r_overflow;
  logic                  r_protocol_err;

  logic                  w_fire;
  logic [2*DATA_W-1:0]   w_prod_u;
  logic [2*DATA_W-1:0]   w_prod_s;
  logic [ACC_W-1:0]      w_ext;
  logic [ACC_W:0]        w_sum_s;
  logic [ACC_W:0]        w_sum_u;
  logic                  w_ovf;
  logic [ACC_W-1:0]      w_acc_nxt;

  assign w_fire = west_valid & north_valid & (r_state == ST_ACC) & ~clear;

  // Operands widened to 2*DATA_W first so the truncated product is exact in both modes
  assign w_prod_u = {{DATA_W{1'b0}}, west_data} * {{DATA_W{1'b0}}, north_data};
  assign w_prod_s = {{DATA_W{west_data[DATA_W-1]}}, west_data} *
                    {{DATA_W{north_data[DATA_W-1]}}, north_data};

  assign w_ext   = r_prod_s ? ACC_W'($signed(r_prod)) : ACC_W'(r_prod);
  assign w_sum_s = {r_acc[ACC_W-1], r_acc} + {w_ext[ACC_W-1], w_ext};
  assign w_sum_u = {1'b0, r_acc} + {1'b0, w_ext};
  assign w_ovf   = r_prod_s ? (w_sum_s[ACC_W] ^ w_sum_s[ACC_W-1]) : w_sum_u[ACC_W];

  always_comb begin
    w_acc_nxt = w_sum_u[ACC_W-1:0];
    if (w_ovf && (SAT_EN != 0)) begin
      if (!r_prod_s)
        w_acc_nxt = {ACC_W{1'b1}};
      else if (w_sum_s[ACC_W])
        w_acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
      else
        w_acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_east_data   <= '0;
      r_east_valid  <= 1'b0;
      r_south_data  <= '0;
      r_south_valid <= 1'b0;
    end else begin
      r_east_data   <= west_data;
      r_east_valid  <= west_valid;
      r_south_data  <= north_data;
      r_south_valid <= north_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_ACC;
      r_prod          <= '0;
      r_prod_s        <= 1'b0;
      r_prod_v        <= 1'b0;
      r_acc           <= '0;
      r_acc_out       <= '0;
      r_acc_out_valid <= 1'b0;
      r_mac_count     <= '0;
      r_overflow      <= 1'b0;
      r_protocol_err  <= 1'b0;
    end else if (clear) begin
      r_state         <= ST_ACC;
      r_prod_v        <= 1'b0;
      r_acc           <= '0;
      r_acc_out_valid <= 1'b0;
      r_mac_count     <= '0;
      r_overflow      <= 1'b0;
      r_protocol_err  <= 1'b0;
    end else begin
      r_prod_v <= w_fire;
      if (w_fire) begin
        r_prod   <= mode_signed ? w_prod_s : w_prod_u;
        r_prod_s <= mode_signed;
      end
      if (r_prod_v) begin
        r_acc <= w_acc_nxt;
        if (r_mac_count != {CNT_W{1'b1}})
          r_mac_count <= r_mac_count + 1'b1;
        if (w_ovf)
          r_overflow <= 1'b1;
      end
      if ((r_state == ST_ACC) && (west_valid ^ north_valid))
        r_protocol_err <= 1'b1;
      case (r_state)
        ST_ACC: begin
          r_acc_out_valid <= 1'b0;
          if (drain)
            r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          r_acc_out_valid <= 1'b0;
          r_state         <= ST_EMIT;
        end
        ST_EMIT: begin
          r_acc_out       <= r_acc;
          r_acc_out_valid <= 1'b1;
          r_state         <= ST_PASS;
        end
        ST_PASS: begin
          r_acc_out       <= acc_in;
          r_acc_out_valid <= acc_in_valid;
        end
        default: r_state <= ST_ACC;
      endcase
    end
  end

  assign east_data     = r_east_data;
  assign east_valid    = r_east_valid;
  assign south_data    = r_south_data;
  assign south_valid   = r_south_valid;
  assign acc_out       = r_acc_out;
  assign acc_out_valid = r_acc_out_valid;
  assign mac_count     = r_mac_count;
  assign overflow      = r_overflow;
  assign protocol_err  = r_protocol_err;

endmodule
